verificador_sequencia: RTL and testbench

Parametrised round engine for the note-memory game: owns a writable sequence RAM, replays the first *r* notes of round *r*, then checks each player press against that RAM. It counts errors and timeouts and accumulates a saturating score. It generalises the fixed 7-button / 16-note / single-ROM datapath to N buttons, configurable depth, loadable songs, an error budget and a built-in round FSM. It sits between the button synchroniser and the display/Arduino output muxes.

---
 rtl/verificador_pkg.sv | 25 ++
 rtl/ram_sequencia.sv | 28 ++
 rtl/verificador_sequencia.sv | 192 +++++++++++++++++++
 tb/tb_verificador_sequencia.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verificador_pkg.sv
// Shared state codes and width helpers for the note-memory round engine.
package verificador_pkg;

   localparam logic [2:0] ST_OCIOSO  = 3'd0;
   localparam logic [2:0] ST_MOSTRA  = 3'd1;
   localparam logic [2:0] ST_ESPERA  = 3'd2;
   localparam logic [2:0] ST_COMPARA = 3'd3;
   localparam logic [2:0] ST_VITORIA = 3'd4;
   localparam logic [2:0] ST_DERROTA = 3'd5;

   typedef enum logic [2:0] {
      OCIOSO  = ST_OCIOSO,
      MOSTRA  = ST_MOSTRA,
      ESPERA  = ST_ESPERA,
      COMPARA = ST_COMPARA,
      VITORIA = ST_VITORIA,
      DERROTA = ST_DERROTA
   } estado_t;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int largura(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ram_sequencia.sv
// Sequence RAM: one write port, registered read whose output clears on reset.
module ram_sequencia #(
   parameter int PROF = 16,
   parameter int LARG = 7,
   parameter int AW   = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [LARG-1:0] wdata,
   input  logic [AW-1:0]   raddr,
   output logic [LARG-1:0] rdata
);

   logic [LARG-1:0] mem [PROF];

   // Contents are deliberately untouched by reset so a loaded song survives.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) rdata <= '0;
      else          rdata <= mem[raddr];
   end

endmodule

// File: rtl/verificador_sequencia.sv
// Round engine: replays the first r notes of round r, then checks each press
// against the sequence RAM, tracking errors, timeouts and a saturating score.
module verificador_sequencia
   import verificador_pkg::*;
#(
   parameter int N_BOTOES  = 7,
   parameter int PROF      = 16,
   parameter int T_NOTA    = 500,
   parameter int T_ESPERA  = 60000,
   parameter int ERROS_MAX = 3,
   parameter int PONTOS_W  = 8
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              iniciar,
   input  logic [N_BOTOES-1:0]               botoes,
   input  logic                              seq_we,
   input  logic [largura(PROF)-1:0]          seq_addr,
   input  logic [N_BOTOES-1:0]               seq_data,
   input  logic [largura(PROF):0]            limite,
   output logic [N_BOTOES-1:0]               esperado,
   output logic                              mostra_valido,
   output logic [largura(PROF):0]            rodada,
   output logic [largura(PROF)-1:0]          jogada,
   output logic                              acerto,
   output logic                              erro,
   output logic                              timeout,
   output logic                              vitoria,
   output logic                              derrota,
   output logic [largura(ERROS_MAX+1)-1:0]   erros,
   output logic [PONTOS_W-1:0]               pontos,
   output logic [2:0]                        db_estado
);

   localparam int AW     = largura(PROF);
   localparam int RW     = AW + 1;
   localparam int EW     = largura(ERROS_MAX + 1);
   localparam int SW     = largura(T_NOTA);
   localparam int TW     = largura(T_ESPERA);
   localparam int SOMA_W = ((PONTOS_W > RW) ? PONTOS_W : RW) + 1;

   localparam logic [SW-1:0]       SLOT_FIM = SW'(T_NOTA - 1);
   localparam logic [TW-1:0]       TMO_FIM  = TW'(T_ESPERA - 1);
   localparam logic [EW-1:0]       ERRO_LIM = EW'(ERROS_MAX - 1);
   localparam logic [PONTOS_W-1:0] PMAX     = '1;

   estado_t               estado, estado_nx;
   logic [AW-1:0]         nota, jogada_r, addr;
   logic [RW-1:0]         rodada_r, lim;
   logic [SW-1:0]         slot;
   logic [TW-1:0]         tcnt;
   logic [EW-1:0]         erros_r;
   logic [PONTOS_W-1:0]   pontos_r;
   logic [N_BOTOES-1:0]   latch;
   logic [SOMA_W-1:0]     soma;
   logic                  prev_or;
   logic                  liberado, tem_jogada, fim_slot, ultima_nota, ultima_jog;
   logic                  igual, estoura, sucesso, falha, esgotou;

   ram_sequencia #(.PROF(PROF), .LARG(N_BOTOES), .AW(AW)) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (seq_we && liberado),
      .waddr   (seq_addr),
      .wdata   (seq_data),
      .raddr   (addr),
      .rdata   (esperado)
   );

   always_comb begin
      lim = limite;
      if (limite == '0)              lim = RW'(1);
      else if (limite > RW'(PROF))   lim = RW'(PROF);
   end

   assign liberado    = (estado == OCIOSO) || (estado == VITORIA) || (estado == DERROTA);
   assign tem_jogada  = (|botoes) && !prev_or;
   assign fim_slot    = (estado == MOSTRA) && (slot == SLOT_FIM);
   assign ultima_nota = {1'b0, nota} == (rodada_r - RW'(1));
   assign ultima_jog  = {1'b0, jogada_r} == (rodada_r - RW'(1));
   assign igual       = (latch == esperado);
   // A press landing on the final wait cycle takes priority over the timeout.
   assign estoura     = (estado == ESPERA) && (tcnt == TMO_FIM) && !tem_jogada;
   assign sucesso     = (estado == COMPARA) && igual;
   assign falha       = ((estado == COMPARA) && !igual) || estoura;
   assign esgotou     = (erros_r == ERRO_LIM);
   assign soma        = SOMA_W'(pontos_r) + SOMA_W'(rodada_r);

   always_ff @(posedge clock) begin
      if (!reset_n) estado <= OCIOSO;
      else          estado <= estado_nx;
   end

   always_comb begin
      estado_nx = estado;
      case (estado)
         OCIOSO, VITORIA, DERROTA:
            if (iniciar) estado_nx = MOSTRA;
         MOSTRA:
            if (fim_slot && ultima_nota) estado_nx = ESPERA;
         ESPERA:
            if (tem_jogada)   estado_nx = COMPARA;
            else if (estoura) estado_nx = esgotou ? DERROTA : MOSTRA;
         COMPARA:
            if (!igual)          estado_nx = esgotou ? DERROTA : MOSTRA;
            else if (!ultima_jog) estado_nx = ESPERA;
            else                 estado_nx = (rodada_r >= lim) ? VITORIA : MOSTRA;
         default:
            estado_nx = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         prev_or  <= 1'b0;
         latch    <= '0;
         tcnt     <= '0;
         slot     <= '0;
         nota     <= '0;
         jogada_r <= '0;
         addr     <= '0;
         rodada_r <= '0;
         erros_r  <= '0;
         pontos_r <= '0;
      end else begin
         prev_or <= |botoes;
         if ((estado == ESPERA) && tem_jogada) latch <= botoes;
         tcnt <= (estado == ESPERA) ? tcnt + 1'b1 : '0;
         slot <= ((estado == MOSTRA) && !fim_slot) ? slot + 1'b1 : '0;

         // The read address tracks the note being shown, then the next expected press.
         case (estado)
            MOSTRA:
               if (fim_slot) begin
                  if (ultima_nota) begin
                     nota     <= '0;
                     addr     <= '0;
                     jogada_r <= '0;
                  end else begin
                     nota <= nota + 1'b1;
                     addr <= nota + 1'b1;
                  end
               end
            ESPERA:
               if (estoura) begin
                  nota     <= '0;
                  addr     <= '0;
                  jogada_r <= '0;
               end
            COMPARA:
               if (sucesso && !ultima_jog) begin
                  jogada_r <= jogada_r + 1'b1;
                  addr     <= jogada_r + 1'b1;
               end else begin
                  nota     <= '0;
                  addr     <= '0;
                  jogada_r <= '0;
               end
            default:
               if (iniciar) begin
                  nota     <= '0;
                  addr     <= '0;
                  jogada_r <= '0;
               end
         endcase

         if (liberado && iniciar) begin
            rodada_r <= RW'(1);
            erros_r  <= '0;
            pontos_r <= '0;
         end
         if (sucesso && ultima_jog) begin
            pontos_r <= (soma > SOMA_W'(PMAX)) ? PMAX : soma[PONTOS_W-1:0];
            if (rodada_r < lim) rodada_r <= rodada_r + 1'b1;
         end
         if (falha) erros_r <= erros_r + 1'b1;
      end
   end

   assign mostra_valido = (estado == MOSTRA) && (slot != '0);
   assign rodada        = rodada_r;
   assign jogada        = jogada_r;
   assign acerto        = sucesso;
   assign erro          = falha;
   assign timeout       = estoura;
   assign vitoria       = (estado == VITORIA);
   assign derrota       = (estado == DERROTA);
   assign erros         = erros_r;
   assign pontos        = pontos_r;
   assign db_estado     = estado;

endmodule

// File: tb/tb_verificador_sequencia.sv
// Self-checking bench for verificador_sequencia; a second instance with a
// 3-bit score shares all inputs so score saturation is reachable.
module tb_verificador_sequencia;

   logic       clock, reset_n, iniciar, seq_we;
   logic [6:0] botoes, seq_data;
   logic [1:0] seq_addr;
   logic [2:0] limite;

   logic [6:0] esperado;
   logic       mostra_valido, acerto, erro, timeout, vitoria, derrota;
   logic [2:0] rodada, db_estado;
   logic [1:0] jogada, erros;
   logic [3:0] pontos;

   logic [6:0] s_esperado;
   logic       s_mostra_valido, s_acerto, s_erro, s_timeout, s_vitoria, s_derrota;
   logic [2:0] s_rodada, s_db_estado;
   logic [1:0] s_jogada, s_erros;
   logic [2:0] s_pontos;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_q[$];
   logic [2:0] obs_q[$];
   logic [6:0] rep_q[$];
   int         rep_valid;
   logic [6:0] ram_m [4];

   verificador_sequencia #(.N_BOTOES(7), .PROF(4), .T_NOTA(4), .T_ESPERA(20),
                           .ERROS_MAX(2), .PONTOS_W(4)) dut (
      .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .botoes(botoes),
      .seq_we(seq_we), .seq_addr(seq_addr), .seq_data(seq_data), .limite(limite),
      .esperado(esperado), .mostra_valido(mostra_valido), .rodada(rodada),
      .jogada(jogada), .acerto(acerto), .erro(erro), .timeout(timeout),
      .vitoria(vitoria), .derrota(derrota), .erros(erros), .pontos(pontos),
      .db_estado(db_estado)
   );

   verificador_sequencia #(.N_BOTOES(7), .PROF(4), .T_NOTA(4), .T_ESPERA(20),
                           .ERROS_MAX(2), .PONTOS_W(3)) u_sat (
      .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .botoes(botoes),
      .seq_we(seq_we), .seq_addr(seq_addr), .seq_data(seq_data), .limite(limite),
      .esperado(s_esperado), .mostra_valido(s_mostra_valido), .rodada(s_rodada),
      .jogada(s_jogada), .acerto(s_acerto), .erro(s_erro), .timeout(s_timeout),
      .vitoria(s_vitoria), .derrota(s_derrota), .erros(s_erros), .pontos(s_pontos),
      .db_estado(s_db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observed event pulses: {acerto, erro, timeout}
   always @(negedge clock)
      if (reset_n && (acerto || erro || timeout)) obs_q.push_back({acerto, erro, timeout});

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
   endtask

   task automatic load_ram(input logic [6:0] a, b, c, d);
      ram_m[0] = a; ram_m[1] = b; ram_m[2] = c; ram_m[3] = d;
      for (int i = 0; i < 4; i++) begin
         seq_we = 1'b1; seq_addr = 2'(i); seq_data = ram_m[i];
         tick(1);
      end
      seq_we = 1'b0;
   endtask

   task automatic start(input logic [2:0] lim);
      limite = lim; iniciar = 1'b1;
      tick(1);
      iniciar = 1'b0;
   endtask

   // Records the note shown in each replay slot until ESPERA is reached.
   task automatic collect();
      logic prev, ok;
      rep_q.delete(); rep_valid = 0; prev = 1'b0; ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         if (db_estado == 3'd2) begin ok = 1'b1; break; end
         if (mostra_valido && !prev) rep_q.push_back(esperado);
         if (mostra_valido) rep_valid++;
         prev = mostra_valido;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL replay_wait state=%0d want ESPERA", db_estado); end
   endtask

   task automatic press(input logic [6:0] v, input logic [2:0] ev);
      logic ok;
      ok = 1'b0;
      exp_q.push_back(ev);
      for (int k = 0; k < 400; k++) begin
         if (db_estado == 3'd2) begin ok = 1'b1; break; end
         @(negedge clock);
      end
      total++;
      if (!ok) begin bad++; $display("FAIL press_wait state=%0d want ESPERA", db_estado); end
      @(posedge clock); #1 botoes = v;
      @(posedge clock); #1 botoes = '0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; iniciar = 1'b0; botoes = '0; seq_we = 1'b0;
      seq_addr = '0; seq_data = '0; limite = 3'd2;
      repeat (3) @(posedge clock);
      @(negedge clock);
      total++;
      if ({esperado, mostra_valido, rodada, jogada, acerto, erro, timeout, vitoria,
           derrota, erros, pontos, db_estado} !== '0) begin
         bad++; $display("FAIL reset_outputs got esp=%h rod=%0d st=%0d pts=%0d want all 0",
                         esperado, rodada, db_estado, pontos);
      end
      @(posedge clock); #1 reset_n = 1'b1;
   endtask

   task automatic test_win();
      load_ram(7'h01, 7'h02, 7'h04, 7'h08);
      start(3'd2);
      collect();
      total++;
      if (rep_q.size() != 1 || rep_q[0] !== 7'h01 || rep_valid != 3 || rodada !== 3'd1) begin
         bad++; $display("FAIL win_round1_replay got n=%0d valid=%0d rod=%0d want n=1 note=01 valid=3 rod=1",
                         rep_q.size(), rep_valid, rodada);
      end
      press(7'h01, 3'b100);
      collect();
      total++;
      if (rep_q.size() != 2 || rep_q[0] !== 7'h01 || rep_q[1] !== 7'h02 || rodada !== 3'd2) begin
         bad++; $display("FAIL win_round2_replay got n=%0d rod=%0d want notes 01,02 rod=2",
                         rep_q.size(), rodada);
      end
      press(7'h01, 3'b100);
      press(7'h02, 3'b100);
      @(negedge clock);
      total++;
      if (vitoria !== 1'b1 || pontos !== 4'd3 || db_estado !== 3'd4) begin
         bad++; $display("FAIL win_final got vit=%b pts=%0d st=%0d want vit=1 pts=3 st=4",
                         vitoria, pontos, db_estado);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL win_event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [2:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL win_event got %b want %b", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_wrong();
      start(3'd4);
      collect();
      press(7'h04, 3'b010);
      @(negedge clock);
      total++;
      if (erros !== 2'd1 || db_estado !== 3'd1) begin
         bad++; $display("FAIL wrong_first got erros=%0d st=%0d want erros=1 st=1", erros, db_estado);
      end
      collect();
      total++;
      if (rep_q.size() != 1 || rep_q[0] !== 7'h01 || rodada !== 3'd1 || pontos !== 4'd0) begin
         bad++; $display("FAIL wrong_replay got n=%0d rod=%0d pts=%0d want n=1 note=01 rod=1 pts=0",
                         rep_q.size(), rodada, pontos);
      end
      press(7'h04, 3'b010);
      @(negedge clock);
      total++;
      if (derrota !== 1'b1 || erros !== 2'd2 || db_estado !== 3'd5) begin
         bad++; $display("FAIL wrong_defeat got der=%b erros=%0d st=%0d want der=1 erros=2 st=5",
                         derrota, erros, db_estado);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL wrong_event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [2:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL wrong_event got %b want %b", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_timeout();
      int n;
      start(3'd4);
      collect();
      exp_q.push_back(3'b011);
      n = 1;
      while (n < 40 && !timeout) begin @(negedge clock); n++; end
      total++;
      if (n != 20 || erro !== 1'b1) begin
         bad++; $display("FAIL timeout_cycle got cycle=%0d erro=%b want cycle=20 erro=1", n, erro);
      end
      collect();
      exp_q.push_back(3'b100);
      repeat (19) @(posedge clock);
      #1 botoes = 7'h01;
      @(posedge clock); #1 botoes = '0;
      @(posedge clock); #1;
      @(negedge clock);
      total++;
      if (db_estado !== 3'd1 || rodada !== 3'd2 || pontos !== 4'd1 || erros !== 2'd1) begin
         bad++; $display("FAIL timeout_late_press got st=%0d rod=%0d pts=%0d erros=%0d want 1 2 1 1",
                         db_estado, rodada, pontos, erros);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL timeout_event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [2:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL timeout_event got %b want %b", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_held();
      do_reset();
      start(3'd4);
      botoes = 7'h01;
      collect();
      @(posedge clock); #1 botoes = 7'h03;
      tick(3);
      @(negedge clock);
      total++;
      if (db_estado !== 3'd2 || obs_q.size() != 0) begin
         bad++; $display("FAIL held_no_press got st=%0d events=%0d want st=2 events=0",
                         db_estado, obs_q.size());
      end
      @(posedge clock); #1 botoes = '0;
      tick(1);
      press(7'h01, 3'b100);
      @(negedge clock);
      total++;
      if (rodada !== 3'd2 || db_estado !== 3'd1) begin
         bad++; $display("FAIL held_repress got rod=%0d st=%0d want rod=2 st=1", rodada, db_estado);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL held_event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [2:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL held_event got %b want %b", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_saturate();
      do_reset();
      start(3'd4);
      seq_we = 1'b1; seq_addr = 2'd0; seq_data = 7'h40;
      tick(1);
      seq_we = 1'b0;
      for (int r = 1; r <= 4; r++) begin
         collect();
         total++;
         if (rep_q.size() != r || rodada !== 3'(r)) begin
            bad++; $display("FAIL sat_replay_len r=%0d got n=%0d rod=%0d", r, rep_q.size(), rodada);
         end
         for (int j = 0; j < r && j < rep_q.size(); j++) begin
            total++;
            if (rep_q[j] !== ram_m[j]) begin
               bad++; $display("FAIL sat_replay_note r=%0d j=%0d got %h want %h", r, j, rep_q[j], ram_m[j]);
            end
         end
         for (int j = 0; j < r; j++) press(ram_m[j], 3'b100);
      end
      @(negedge clock);
      total++;
      if (vitoria !== 1'b1 || pontos !== 4'd10 || s_pontos !== 3'd7) begin
         bad++; $display("FAIL sat_score got vit=%b pts=%0d sat_pts=%0d want vit=1 pts=10 sat_pts=7",
                         vitoria, pontos, s_pontos);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL sat_event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [2:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL sat_event got %b want %b", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      load_ram(7'h10, 7'h20, 7'h40, 7'h01);
      start(3'd4);
      collect();
      total++;
      if (rep_q.size() != 1 || rep_q[0] !== 7'h10) begin
         bad++; $display("FAIL rmid_new_song got n=%0d want note 10", rep_q.size());
      end
      @(posedge clock); #1 reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      total++;
      if ({esperado, mostra_valido, rodada, jogada, acerto, erro, timeout, vitoria,
           derrota, erros, pontos, db_estado} !== '0) begin
         bad++; $display("FAIL rmid_outputs got esp=%h rod=%0d st=%0d want all 0",
                         esperado, rodada, db_estado);
      end
      @(posedge clock); #1 reset_n = 1'b1;
      exp_q.delete(); obs_q.delete();
      start(3'd4);
      collect();
      total++;
      if (rep_q.size() != 1 || rep_q[0] !== 7'h10) begin
         bad++; $display("FAIL rmid_ram_kept got n=%0d want note 10", rep_q.size());
      end
      press(7'h10, 3'b100);
      @(negedge clock);
      total++;
      if (pontos !== 4'd1 || rodada !== 3'd2) begin
         bad++; $display("FAIL rmid_resume got pts=%0d rod=%0d want pts=1 rod=2", pontos, rodada);
      end
      do_reset();
      start(3'd0);
      collect();
      press(7'h10, 3'b100);
      @(negedge clock);
      total++;
      if (vitoria !== 1'b1 || pontos !== 4'd1 || rodada !== 3'd1) begin
         bad++; $display("FAIL limit_zero got vit=%b pts=%0d rod=%0d want vit=1 pts=1 rod=1",
                         vitoria, pontos, rodada);
      end
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rmid_event_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [2:0] e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front();
         total++;
         if (o !== e) begin bad++; $display("FAIL rmid_event got %b want %b", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_win();
      test_wrong();
      test_timeout();
      test_held();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
